// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
//   Bundles the operand, control and HI/LO result signals of mul_div_unit.
//   Signal names keep the unit's i_/o_ prefixes as seen from the unit.
//   Ports:
//     i_start   start an operation (taken only while idle)
//     i_op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     i_a/i_b   operand A (dividend, MTHI/MTLO source) / operand B (divisor)
//     i_we_hi   MTHI write strobe
//     i_we_lo   MTLO write strobe
//     o_busy    operation in progress
//     o_done    one-cycle pulse: HI/LO hold the new result
//     o_dz      divide-by-zero flag, meaningful while o_done=1
//     o_hi/o_lo architectural HI/LO registers
//   Modports: master drives the i_* side (datapath / bench), slave is the unit.
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_we_hi;
  logic             i_we_lo;
  logic             o_busy;
  logic             o_done;
  logic             o_dz;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_a, i_b, i_we_hi, i_we_lo,
    input  o_busy, o_done, o_dz, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_we_hi, i_we_lo,
    output o_busy, o_done, o_dz, o_hi, o_lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
//   One iteration per clock for WIDTH clocks, then a one-cycle DONE state.
//   Ports:
//     i_clk   clock, rising edge
//     i_rst   synchronous reset, active-high
//     bus     mul_div_unit_if slave (operands, control, HI/LO results)
//   Datapath: a single 2*WIDTH accumulator serves both operations.
//     MUL: {upper, multiplier} shifts right; upper += multiplicand when lsb=1.
//     DIV: {remainder, dividend/quotient} shifts left with restoring subtract.
//   Signed ops work on magnitudes; signs are re-applied when HI/LO load.
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // multiplicand magnitude
  logic [WIDTH-1:0]   b_q, b_d;          // divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;    // product / quotient negative
  logic               rneg_q, rneg_d;    // remainder takes dividend sign
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand conditioning for capture at start
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_sgn = ~bus.i_op[0] & bus.i_a[WIDTH-1];
  assign b_sgn = ~bus.i_op[0] & bus.i_b[WIDTH-1];
  assign a_mag = a_sgn ? -bus.i_a : bus.i_a;
  assign b_mag = b_sgn ? -bus.i_b : bus.i_b;

  // One iteration of either algorithm
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   rem_w, quo_w;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign step_acc  = op_q[1]
                   ? (div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                   : {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_w     = step_acc[2*WIDTH-1:WIDTH];
  assign quo_w     = step_acc[WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_we_hi) hi_d = bus.i_a;
        if (bus.i_we_lo) lo_d = bus.i_a;
        if (bus.i_start) begin
          state_d = CALC;
          op_d    = bus.i_op;
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = bus.i_op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          qneg_d  = a_sgn ^ b_sgn;
          rneg_d  = a_sgn;
          dz_d    = bus.i_op[1] & (bus.i_b == '0);
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (op_q[1]) begin
            // With a zero divisor every trial succeeds, so the remainder
            // ends up as |a|; restoring the dividend sign yields i_a exactly.
            hi_d = rneg_q ? -rem_w : rem_w;
            lo_d = dz_q ? '1 : (qneg_q ? -quo_w : quo_w);
          end else begin
            {hi_d, lo_d} = qneg_q ? -step_acc : step_acc;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: the datapath registers are reset along with the control state so
    // an abandoned operation leaves nothing that could leak into a later one.
    if (i_rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.o_busy = (state_q != IDLE);
  assign bus.o_done = (state_q == DONE);
  assign bus.o_dz   = (state_q == DONE) & dz_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed self-checking bench for mul_div_unit. Expected values are
//   hand-computed constants; model_hi/model_lo track what HI/LO should hold.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation from start to its DONE cycle.
  //   inj > 0 : at cycle inj after E0, pulse a conflicting start + MTHI/MTLO
  //   we      : assert MTHI together with the start
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dz, input int inj, input logic we);
    int  k;
    bit  got;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_we_hi = we;
    @(posedge clk);   // E0
    #1;
    bus.i_start = 1'b0;
    bus.i_we_hi = 1'b0;
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
    bus.i_op    = 2'($urandom_range(0, 3));
    if (we) model_hi = a;
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, " busy after E0"}, 64'(bus.o_busy), 64'(1));
        check({tag, " hi after E0"}, 64'(bus.o_hi), 64'(model_hi));
      end
      if (k == 32) begin
        check({tag, " hi held before E32"}, 64'(bus.o_hi), 64'(model_hi));
        check({tag, " lo held before E32"}, 64'(bus.o_lo), 64'(model_lo));
      end
      if (k == inj) begin
        bus.i_start = 1'b1;
        bus.i_op    = 2'b11;
        bus.i_a     = 32'h0000_0055;
        bus.i_b     = 32'd7;
        bus.i_we_hi = 1'b1;
        bus.i_we_lo = 1'b1;
      end
      if (inj > 0 && k == inj + 1) begin
        bus.i_start = 1'b0;
        bus.i_we_hi = 1'b0;
        bus.i_we_lo = 1'b0;
      end
      if (bus.o_done) got = 1'b1;
    end
    check({tag, " done latency"}, 64'(k), 64'(33));
    check({tag, " hi"}, 64'(bus.o_hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.o_lo), 64'(exp_lo));
    check({tag, " dz"}, 64'(bus.o_dz), 64'(exp_dz));
    check({tag, " busy in done"}, 64'(bus.o_busy), 64'(1));
    @(negedge clk);
    check({tag, " done pulse one cycle"}, 64'(bus.o_done), 64'(0));
    check({tag, " idle after done"}, 64'(bus.o_busy), 64'(0));
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    int dones;
    bus.i_start = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_we_hi = 1'b0;
    bus.i_we_lo = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(bus.o_busy), 64'(0));
    check("reset done", 64'(bus.o_done), 64'(0));
    check("reset dz",   64'(bus.o_dz),   64'(0));
    check("reset hi",   64'(bus.o_hi),   64'(0));
    check("reset lo",   64'(bus.o_lo),   64'(0));
    rst = 1'b0;

    run_op("multu max*2", 2'b01, 32'hFFFF_FFFF, 32'd2,
           32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);
    run_op("mult -3*7",   2'b00, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0);
    run_op("divu 100/7",  2'b11, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 0, 1'b0);
    run_op("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run_op("div 5/0",     2'b10, 32'd5, 32'd0,
           32'd5, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("div -9/0",    2'b10, 32'hFFFF_FFF7, 32'd0,
           32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("divu big/0",  2'b11, 32'h8000_0007, 32'd0,
           32'h8000_0007, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("div min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    // (-2^31)^2 = 2^62, with MTHI issued on the start edge
    run_op("mult min*min mthi", 2'b00, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0000_0000, 1'b0, 0, 1'b1);
    run_op("multu 3*4 busy start", 2'b01, 32'd3, 32'd4,
           32'h0000_0000, 32'd12, 1'b0, 5, 1'b0);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = 2'b01;
    bus.i_a     = 32'hFFFF_FFFF;
    bus.i_b     = 32'd2;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);   // E10
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midop rst busy", 64'(bus.o_busy), 64'(0));
    check("midop rst hi",   64'(bus.o_hi),   64'(0));
    check("midop rst lo",   64'(bus.o_lo),   64'(0));
    check("midop rst done", 64'(bus.o_done), 64'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    check("no stale done", 64'(dones), 64'(0));
    model_hi = '0;
    model_lo = '0;

    // MTHI alone, then MTHI+MTLO together
    @(negedge clk);
    bus.i_a     = 32'h0000_1234;
    bus.i_we_hi = 1'b1;
    @(posedge clk);
    #1;
    bus.i_we_hi = 1'b0;
    @(negedge clk);
    check("mthi hi", 64'(bus.o_hi), 64'(32'h0000_1234));
    check("mthi lo untouched", 64'(bus.o_lo), 64'(0));
    bus.i_a     = 32'h0000_ABCD;
    bus.i_we_hi = 1'b1;
    bus.i_we_lo = 1'b1;
    @(posedge clk);
    #1;
    bus.i_we_hi = 1'b0;
    bus.i_we_lo = 1'b0;
    @(negedge clk);
    check("mthi+mtlo hi", 64'(bus.o_hi), 64'(32'h0000_ABCD));
    check("mthi+mtlo lo", 64'(bus.o_lo), 64'(32'h0000_ABCD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
